// File: rtl/rms_result_fifo.sv
// Result FIFO behind the RMS engine: tags each finished RMS value with a window
// sequence number and buffers it first-word-fall-through for the HPS bridge.
module rms_result_fifo #(
  parameter int WIDTH_DATA = 28,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int SEQ_W      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WIDTH_DATA-1:0]       rms_in,
  input  logic                        rms_valid,
  input  logic                        rd_req,
  input  logic                        clear_ovf,
  output logic [SEQ_W+WIDTH_DATA-1:0] rd_data,
  output logic                        rd_valid,
  output logic [ADDR_W:0]             fifo_count,
  output logic                        overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [SEQ_W+WIDTH_DATA-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]           wr_ptr;
  logic [ADDR_W-1:0]           rd_ptr;
  logic [SEQ_W-1:0]            seq;
  logic [ADDR_W:0]             count_nxt;
  logic                        full;
  logic                        pop;
  logic                        wr_en;
  logic                        drop;

  // A same-cycle pop frees a slot, so a write into a full FIFO still succeeds.
  assign full  = (fifo_count == FULL_CNT);
  assign pop   = rd_req && rd_valid;
  assign wr_en = rms_valid && (!full || pop);
  assign drop  = rms_valid && full && !pop;

  always_comb begin
    count_nxt = fifo_count;
    if (wr_en && !pop)
      count_nxt = fifo_count + (ADDR_W+1)'(1);
    else if (pop && !wr_en)
      count_nxt = fifo_count - (ADDR_W+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      seq        <= '0;
      fifo_count <= '0;
      rd_valid   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + ADDR_W'(1);
      if (rms_valid)
        seq <= seq + SEQ_W'(1);
      fifo_count <= count_nxt;
      rd_valid   <= (count_nxt != '0);
      // Drop beats a same-cycle clear so a lost window is never hidden.
      if (drop)
        overflow <= 1'b1;
      else if (clear_ovf)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= {seq, rms_in};
  end

  assign rd_data = rd_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_rms_result_fifo.sv
// Directed bench for rms_result_fifo: vector table plus queue-model sequences.
module tb_rms_result_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [27:0] rms_in = '0;
  logic        rms_valid = 1'b0;
  logic        rd_req = 1'b0;
  logic        clear_ovf = 1'b0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [3:0]  fifo_count;
  logic        overflow;

  always #5 clk = ~clk;

  rms_result_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .rms_in     (rms_in),
    .rms_valid  (rms_valid),
    .rd_req     (rd_req),
    .clear_ovf  (clear_ovf),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  typedef struct {
    logic        rst;
    logic        v;
    logic [27:0] d;
    logic        rd;
    logic        clr;
    logic        e_rv;
    logic [31:0] e_data;
    logic [3:0]  e_cnt;
    logic        e_ovf;
  } vec_t;

  vec_t        vt[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] q[$];
  logic [3:0]  mseq;
  logic        movf;

  function automatic vec_t mk(logic rst, logic v, logic [27:0] d, logic rd, logic clr,
                              logic e_rv, logic [31:0] e_data, logic [3:0] e_cnt, logic e_ovf);
    vec_t r;
    r.rst = rst; r.v = v; r.d = d; r.rd = rd; r.clr = clr;
    r.e_rv = e_rv; r.e_data = e_data; r.e_cnt = e_cnt; r.e_ovf = e_ovf;
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic drive(input logic r, input logic v, input logic [27:0] d,
                       input logic rd, input logic clr);
    @(negedge clk);
    reset = r; rms_valid = v; rms_in = d; rd_req = rd; clear_ovf = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string nm);
    check({nm, " rd_valid"}, 32'(rd_valid), 32'(q.size() != 0));
    check({nm, " rd_data"}, rd_data, (q.size() != 0) ? q[0] : 32'h0);
    check({nm, " fifo_count"}, 32'(fifo_count), 32'(q.size()));
    check({nm, " overflow"}, 32'(overflow), 32'(movf));
  endtask

  // Reference behaviour: decide pop/drop from state before the edge.
  task automatic mstep(input logic v, input logic [27:0] d, input logic rd,
                       input logic clr, input string nm);
    bit p;
    bit dr;
    p  = rd && (q.size() != 0);
    dr = v && (q.size() == 8) && !p;
    if (clr) movf = 1'b0;
    if (dr) movf = 1'b1;
    if (p) void'(q.pop_front());
    if (v && !dr) q.push_back({mseq, d});
    if (v) mseq = mseq + 4'd1;
    drive(1'b0, v, d, rd, clr);
    check_model(nm);
  endtask

  initial begin
    int nw;
    int sz;
    logic v;
    logic rd;

    // single write / pop, pop-when-empty
    vt.push_back(mk(1, 0, 0,          0, 0, 0, 32'h0,        0, 0));
    vt.push_back(mk(0, 1, 28'h0000123, 0, 0, 1, 32'h00000123, 1, 0));
    vt.push_back(mk(0, 0, 0,          1, 0, 0, 32'h0,        0, 0));
    vt.push_back(mk(0, 0, 0,          1, 0, 0, 32'h0,        0, 0));
    // fill to 8, drop value 9, drain, gap visible on value 10, clear
    vt.push_back(mk(1, 0, 0,          0, 0, 0, 32'h0,        0, 0));
    for (int k = 1; k <= 8; k++)
      vt.push_back(mk(0, 1, 28'(k), 0, 0, 1, 32'h00000001, 4'(k), 0));
    vt.push_back(mk(0, 1, 28'd9, 0, 0, 1, 32'h00000001, 8, 1));
    for (int i = 1; i <= 7; i++)
      vt.push_back(mk(0, 0, 0, 1, 0, 1, {4'(i), 28'(i + 1)}, 4'(8 - i), 1));
    vt.push_back(mk(0, 0, 0,      1, 0, 0, 32'h0,        0, 1));
    vt.push_back(mk(0, 1, 28'd10, 0, 0, 1, 32'h9000000A, 1, 1));
    vt.push_back(mk(0, 0, 0,      0, 1, 1, 32'h9000000A, 1, 0));
    vt.push_back(mk(0, 0, 0,      1, 0, 0, 32'h0,        0, 0));

    #1;
    check("reset rd_data", rd_data, 32'h0);
    check("reset fifo_count", 32'(fifo_count), 32'h0);

    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].v, vt[i].d, vt[i].rd, vt[i].clr);
      check($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(vt[i].e_rv));
      check($sformatf("vec%0d rd_data", i), rd_data, vt[i].e_data);
      check($sformatf("vec%0d fifo_count", i), 32'(fifo_count), 32'(vt[i].e_cnt));
      check($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vt[i].e_ovf));
    end

    // Table leaves the FIFO empty, overflow clear, ten windows seen.
    q.delete();
    mseq = 4'd10;
    movf = 1'b0;

    // full with simultaneous write and pop
    for (int k = 0; k < 8; k++) mstep(1, 28'h100 + 28'(k), 0, 0, "fill_a");
    mstep(1, 28'h200, 1, 0, "full_wr_pop");
    check("full_wr_pop count", 32'(fifo_count), 32'd8);
    check("full_wr_pop ovf", 32'(overflow), 32'd0);
    for (int k = 0; k < 8; k++) mstep(0, 0, 1, 0, "drain_a");

    // clear and drop in the same cycle: set wins
    for (int k = 0; k < 8; k++) mstep(1, 28'h300 + 28'(k), 0, 0, "fill_b");
    mstep(1, 28'h3FF, 0, 1, "clr_set_collide");
    check("clr_set_collide ovf", 32'(overflow), 32'd1);
    mstep(0, 0, 0, 1, "clear_after_collide");
    for (int k = 0; k < 8; k++) mstep(0, 0, 1, 0, "drain_b");

    // wrap-around: 40 writes, random pops, occupancy held in 1..8
    nw = 0;
    while (nw < 40) begin
      sz = q.size();
      if (sz == 0) begin
        v = 1; rd = 0;
      end else if (sz == 8) begin
        rd = 1; v = 1'($urandom_range(0, 1));
      end else begin
        case ($urandom_range(0, 3))
          0: begin v = 1; rd = 0; end
          1: begin v = 0; rd = (sz > 1); end
          2: begin v = 1; rd = 1; end
          default: begin v = 0; rd = 0; end
        endcase
      end
      mstep(v, 28'h0ABC000 + 28'(nw), rd, 0, $sformatf("wrap%0d", nw));
      if (v) nw++;
    end
    while (q.size() != 0) mstep(0, 0, 1, 0, "wrap_drain");

    // reset mid-operation: 5 entries stored, overflow set
    for (int k = 0; k < 9; k++) mstep(1, 28'h500 + 28'(k), 0, 0, "fill_c");
    for (int k = 0; k < 3; k++) mstep(0, 0, 1, 0, "pop_c");
    check("pre_reset count", 32'(fifo_count), 32'd5);
    check("pre_reset ovf", 32'(overflow), 32'd1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset rd_valid", 32'(rd_valid), 32'd0);
    check("async_reset rd_data", rd_data, 32'h0);
    check("async_reset fifo_count", 32'(fifo_count), 32'd0);
    check("async_reset overflow", 32'(overflow), 32'd0);
    q.delete();
    mseq = 4'd0;
    movf = 1'b0;
    mstep(1, 28'h0000777, 0, 0, "post_reset_write");
    check("post_reset seq", rd_data, 32'h00000777);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rms_result_fifo.md
# rms_result_fifo

Downstream stage of the RMS engine. Captures each finished RMS value on its one-cycle completion strobe and tags it with a 4-bit window sequence number. Holds the tagged results in a small first-word-fall-through FIFO. The HPS side pops them over the HPS-FPGA bridge at its own pace, and the sequence tag plus a sticky overflow flag let software detect lost windows.

## Interface
- WIDTH_DATA, 28, RMS value width; must match the RMS engine output.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- ADDR_W, 3, log2(DEPTH).
- SEQ_W, 4, sequence tag width; WIDTH_DATA + SEQ_W = 32.
- clk  input  1  single system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rms_in  input  WIDTH_DATA  RMS value from the engine, unsigned.
- rms_valid  input  1  one-cycle strobe: rms_in is a new result.
- rd_req  input  1  pop request from the HPS bridge.
- clear_ovf  input  1  one-cycle strobe that clears overflow.
- rd_data  output  32  {seq[SEQ_W-1:0], rms[WIDTH_DATA-1:0]} of the head entry.
- rd_valid  output  1  FIFO non-empty; rd_data is meaningful.
- fifo_count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: at least one result was dropped.

## Operation
- **Storage:** DEPTH x 32 register array, write pointer wr_ptr, read pointer rd_ptr (ADDR_W bits each, natural wrap), occupancy count.
- **seq counter:** SEQ_W bits. Increments by 1, modulo 2^SEQ_W, on every rms_valid, whether or not the result is stored. A dropped result therefore appears to software as a gap in seq.
- **Write:** on rms_valid, if count < DEPTH, or a pop happens in the same cycle:
  - store {seq, rms_in} at wr_ptr, where seq is the value before the increment;
  - advance wr_ptr.
- **Drop:** on rms_valid with count == DEPTH and no same-cycle pop:
  - discard the result;
  - set overflow;
  - still increment seq.
- **Pop:** rd_req while rd_valid=1 advances rd_ptr. rd_req while rd_valid=0 is ignored and has no side effects.
- **Simultaneous write and pop:**
  - count unchanged and both pointers advance;
  - allowed when full: no drop, overflow is not set;
  - when empty, the pop is ignored and the write succeeds, so count becomes 1.
- **Read data:** rd_data is the head entry mem[rd_ptr] when rd_valid=1, and 32'h0 when empty (first-word-fall-through).
- **overflow:** cleared by clear_ovf. If clear_ovf and a drop occur in the same cycle, the set wins and overflow stays 1.
- **Width rule:** rms_in is stored unmodified in bits [27:0]. seq occupies bits [31:28].

## Timing
- Reset (async assert, released synchronously to clk by the system):
  - rd_data=0, rd_valid=0, fifo_count=0, overflow=0;
  - seq=0, both pointers 0;
  - memory contents don't-care.
- Write latency: rms_valid sampled at edge N, then rd_valid, rd_data and fifo_count update after edge N. They are visible in cycle N+1.
- Pop latency: rd_req sampled at edge N, then the next head entry (or rd_valid=0) appears after edge N.
- rd_valid, fifo_count and overflow are registered. rd_data is a mux of registered state with no input-to-output combinational path.
- rms_valid arrives at most once per window (≥ 4 cycles apart) in the system. The block must nevertheless accept back-to-back rms_valid every cycle.
- Reset asserted mid-operation:
  - all stored entries are lost and seq restarts at 0;
  - outputs reach their reset values immediately, without waiting for clk.

## Test plan
- **Single write then pop:** after reset, pulse rms_valid with rms_in=28'h0000123.
  - Next cycle: rd_valid=1, rd_data=32'h00000123, fifo_count=1.
  - Pulse rd_req: then rd_valid=0, rd_data=0, fifo_count=0.
- **Fill and overflow:** write 9 results with values 1..9 and no reads.
  - After writes: fifo_count=8 and overflow=1.
  - Popping all 8 yields seq 0..7 with values 1..8. Value 9 is absent.
  - The next write (value 10) pops out with seq=9 (gap visible).
  - clear_ovf then gives overflow=0.
- **Full with simultaneous write and pop:** with count=8, assert rms_valid and rd_req in the same cycle.
  - Count stays 8, overflow stays 0.
  - The head advances and the new entry lands at the tail.
- **Pop when empty and clear/set collision:**
  - rd_req with FIFO empty: no change anywhere.
  - With FIFO full, assert clear_ovf and a dropping rms_valid together: overflow=1.
- **Wrap-around:** 40 writes interleaved with pops at random spacing, occupancy kept between 1 and 8.
  - Every popped word equals the expected {seq mod 16, value} in order.
  - Pointers and seq wrap cleanly, and seq passes 15 to 0.
- **Reset mid-operation:** with 5 entries stored and overflow=1, assert reset asynchronously between clock edges.
  - Outputs go to 0 immediately.
  - After release, the first write pops out with seq=0.
